uart_rx_frontend: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 86 ++++++++
 rtl/uart_rx_frontend.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq_hz, input int baudrate);
    return (clk_freq_hz + 8 * baudrate) / (OVERSAMPLE * baudrate);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive character buffer with a registered valid/ready read side.
// Define UART_RX_FIFO_EN for a DEPTH-entry circular buffer; otherwise a single holding register.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             pop;
  logic             do_push;
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign pop     = valid_reg && m_ready;
  assign m_valid = valid_reg;
  assign m_data  = data_reg;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      wr_ptr_next, rd_ptr_next;
  logic             valid_next;
  logic             bypass;

  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push     = push && (!full || pop);
  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, do_push};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign valid_next  = (wr_ptr_next != rd_ptr_next);
  // The entry being written is the next head: forward it past the array.
  assign bypass      = do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      valid_reg  <= valid_next;
      if (valid_next) begin
        data_reg <= bypass ? push_data : mem[rd_ptr_next[AW-1:0]];
      end
    end
  end
`else
  assign full    = valid_reg;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (do_push) begin
      valid_reg <= 1'b1;
      data_reg  <= push_data;
    end else if (pop) begin
      valid_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchroniser, 16x oversampling frame FSM and character buffer.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer instead of one holding register.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 9600,
  parameter int DATA_BITS   = 8,
  parameter int USE_PARITY  = 0,
  parameter int ODD_PARITY  = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUDRATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_frontend: CLK_FREQ_HZ too low for BAUDRATE (DIV < 1)");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx_frontend: DATA_BITS must be 5..9");
  end

  // Synchroniser, reset to the idle line level.
  logic [1:0] sync_reg;
  logic [1:0] sync_in;
  logic       rxs;

  assign sync_in = {sync_reg[0], rx_i};
  assign rxs     = sync_reg[1];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sync
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_reg[gi] <= 1'b1;
      else     sync_reg[gi] <= sync_in[gi];
    end
  end

  rx_state_t            state_reg, state_next;
  logic [DIV_W-1:0]     div_cnt_reg;
  logic [3:0]           samp_reg, samp_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 lo_reg, lo_next;
  logic                 mid_reg, mid_next;
  logic                 par_bad_reg, par_bad_next;
  logic                 push_reg, push_next;
  logic [DATA_BITS-1:0] push_data_reg, push_data_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 overrun_reg;
  logic                 buf_full;
  logic                 tick, restart, maj, at_res, at_end;

  assign restart = (state_reg == IDLE) && !rxs;
  assign tick    = (div_cnt_reg == '0);
  assign maj     = (lo_reg & mid_reg) | (lo_reg & rxs) | (mid_reg & rxs);
  assign at_res  = tick && (samp_reg == 4'(SAMPLE_HI));
  assign at_end  = tick && (samp_reg == 4'(OVERSAMPLE - 1));

  // Restarting on the start edge aligns the tick phase with the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 div_cnt_reg <= '0;
    else if (restart || tick) div_cnt_reg <= DIV_W'(DIV - 1);
    else                     div_cnt_reg <= div_cnt_reg - 1'b1;
  end

  always_comb begin
    state_next      = state_reg;
    samp_next       = samp_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    lo_next         = lo_reg;
    mid_next        = mid_reg;
    par_bad_next    = par_bad_reg;
    push_next       = 1'b0;
    push_data_next  = push_data_reg;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;

    if (tick && state_reg != IDLE && state_reg != BREAK) begin
      samp_next = samp_reg + 4'd1;
      if (samp_reg == 4'(SAMPLE_LO))  lo_next  = rxs;
      if (samp_reg == 4'(SAMPLE_MID)) mid_next = rxs;
    end

    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next   = START;
          samp_next    = '0;
          bit_next     = '0;
          par_bad_next = 1'b0;
        end
      end
      START: begin
        if (at_res && maj)  state_next = IDLE;
        else if (at_end)    state_next = DATA;
      end
      DATA: begin
        if (at_res) shift_next = {maj, shift_reg[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_reg == BIT_W'(DATA_BITS - 1))
            state_next = (USE_PARITY != 0) ? PARITY : STOP;
          else
            bit_next = bit_reg + 1'b1;
        end
      end
      PARITY: begin
        if (at_res) par_bad_next = maj ^ (^shift_reg) ^ (ODD_PARITY != 0);
        if (at_end) state_next = STOP;
      end
      STOP: begin
        // Leave at the resolution tick so a back-to-back start bit is not missed.
        if (at_res) begin
          state_next = IDLE;
          if (!maj) begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end else if (par_bad_reg) begin
            parity_err_next = 1'b1;
          end else begin
            push_next      = 1'b1;
            push_data_next = shift_reg;
          end
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      samp_reg       <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      lo_reg         <= 1'b1;
      mid_reg        <= 1'b1;
      par_bad_reg    <= 1'b0;
      push_reg       <= 1'b0;
      push_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      samp_reg       <= samp_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      lo_reg         <= lo_next;
      mid_reg        <= mid_next;
      par_bad_reg    <= par_bad_next;
      push_reg       <= push_next;
      push_data_reg  <= push_data_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= push_reg && buf_full && !(m_valid && m_ready);
    end
  end

  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_reg),
    .push_data (push_data_reg),
    .full      (buf_full),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: 8N1 instance plus an 8E1 instance, 16 clocks per bit.
module tb_uart_rx_frontend;

  localparam int CLK_HZ   = 16000000;
  localparam int BAUD     = 1000000;
  localparam int BIT_CLKS = 16;
`ifdef UART_RX_FIFO_EN
  localparam int BUF_DEPTH = 4;
`else
  localparam int BUF_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       m_ready = 1'b1, m_ready_p = 1'b1;
  logic [7:0] m_data, m_data_p;
  logic       m_valid, m_valid_p;
  logic       pe, fe, ov, pe_p, fe_p, ov_p;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD), .DATA_BITS(8),
    .USE_PARITY(0), .ODD_PARITY(0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_i(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .parity_err(pe), .frame_err(fe), .overrun(ov)
  );

  uart_rx_frontend #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD), .DATA_BITS(8),
    .USE_PARITY(1), .ODD_PARITY(0), .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .rst(rst), .rx_i(rx_p), .m_data(m_data_p), .m_valid(m_valid_p),
    .m_ready(m_ready_p), .parity_err(pe_p), .frame_err(fe_p), .overrun(ov_p)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_bits;
    bit         beat;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  logic [7:0] exp_q_p [$];
  int n_vec = 0, n_err = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, beats = 0;
  int fe_cnt_p = 0, pe_cnt_p = 0, ov_cnt_p = 0, beats_p = 0;
  logic [7:0] held;
  logic       held_v = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    end else begin
      $display("ok   %s: 'h%0h", name, act);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (fe) fe_cnt++;
      if (pe) pe_cnt++;
      if (ov) ov_cnt++;
      if (fe_p) fe_cnt_p++;
      if (pe_p) pe_cnt_p++;
      if (ov_p) ov_cnt_p++;
      if (held_v) begin
        n_vec++;
        if (!m_valid || m_data !== held) begin
          n_err++;
          $display("FAIL hold: got valid=%0b data='h%0h, required valid=1 data='h%0h",
                   m_valid, m_data, held);
        end
      end
      held_v = m_valid && !m_ready;
      held   = m_data;
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL beat: got 'h%0h, required no beat", m_data);
        end else begin
          check("beat", m_data, exp_q.pop_front());
        end
      end
      if (m_valid_p && m_ready_p) begin
        beats_p++;
        if (exp_q_p.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL beat_p: got 'h%0h, required no beat", m_data_p);
        end else begin
          check("beat_p", m_data_p, exp_q_p.pop_front());
        end
      end
    end
  end

  task automatic drive_bit(input bit p, input logic v, input int n = 1);
    if (p) rx_p = v;
    else   rx   = v;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // par < 0: no parity bit in the frame.
  task automatic send(input bit p, input logic [7:0] d, input int par, input logic stop);
    drive_bit(p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
    if (par >= 0) drive_bit(p, par[0]);
    drive_bit(p, stop);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 m_ready = v;
  endtask

  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int fe_exp, beats_exp;

    vecs[0] = '{8'hA5, 1'b1, 0, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 2, 1'b0};
    vecs[2] = '{8'h55, 1'b1, 0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 0, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_errs", {fe, pe, ov}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);

    // Table of 8N1 frames, frame error case included.
    fe_exp = 0;
    beats_exp = 0;
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].stop) fe_exp++;
      if (vecs[i].beat) begin
        exp_q.push_back(vecs[i].data);
        beats_exp++;
      end
      send(0, vecs[i].data, -1, vecs[i].stop);
      if (vecs[i].low_bits > 0) drive_bit(0, 1'b0, vecs[i].low_bits);
      drive_bit(0, 1'b1, 2);
      check("frame_err_cnt", fe_cnt, fe_exp);
      check("beats", beats, beats_exp);
    end
    check("parity_err_cnt", pe_cnt, 0);

    // Short low glitch: rejected, then a clean frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("glitch_beats", beats, beats_exp);
    exp_q.push_back(8'h3C);
    beats_exp++;
    send(0, 8'h3C, -1, 1'b1);
    drive_bit(0, 1'b1, 2);
    check("after_glitch_beats", beats, beats_exp);
    check("after_glitch_fe", fe_cnt, fe_exp);

    // Even parity: bad parity, good parity, then stop low with bad parity.
    send(1, 8'h07, 0, 1'b1);
    drive_bit(1, 1'b1, 2);
    check("p_parity_err", pe_cnt_p, 1);
    check("p_no_beat", beats_p, 0);
    exp_q_p.push_back(8'h07);
    send(1, 8'h07, 1, 1'b1);
    drive_bit(1, 1'b1, 2);
    check("p_beat_cnt", beats_p, 1);
    send(1, 8'h0F, 1, 1'b0);
    drive_bit(1, 1'b0, 1);
    drive_bit(1, 1'b1, 2);
    check("p_frame_err", fe_cnt_p, 1);
    check("p_frame_over_parity", pe_cnt_p, 1);
    check("p_total_beats", beats_p, 1);

    // Back-to-back frames with the consumer stalled.
    set_ready(1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k <= BUF_DEPTH) exp_q.push_back(8'(k));
      send(0, 8'(k), -1, 1'b1);
    end
    drive_bit(0, 1'b1, 2);
    check("overrun_cnt", ov_cnt, 5 - BUF_DEPTH);
    check("stalled_valid", m_valid, 1);
    set_ready(1'b1);
    wait_drain(200);
    repeat (4) @(negedge clk);
    check("overrun_beats", beats, beats_exp + BUF_DEPTH);
    beats_exp = beats_exp + BUF_DEPTH;

    // Reset during data bit 3 with a character waiting.
    set_ready(1'b0);
    send(0, 8'h42, -1, 1'b1);
    drive_bit(0, 1'b1, 1);
    check("pre_rst_valid", m_valid, 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_data", m_data, 0);
    check("rst_mid_errs", {fe, pe, ov}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_bit(0, 1'b1, 2);
    check("post_rst_valid", m_valid, 0);
    set_ready(1'b1);
    exp_q.push_back(8'h81);
    beats_exp++;
    send(0, 8'h81, -1, 1'b1);
    drive_bit(0, 1'b1, 2);
    wait_drain(50);
    check("post_rst_beats", beats, beats_exp);
    check("final_fe", fe_cnt, fe_exp);
    check("final_pe", pe_cnt, 0);
    check("final_ov", ov_cnt, 5 - BUF_DEPTH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
